inject_arbiter: RTL and testbench

INJECT_ARBITER -- requirements
Module: inject_arbiter

---
 rtl/inject_arbiter_if.sv | 23 ++
 rtl/inject_arbiter.sv | 115 +++++++++++
 tb/tb_inject_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/inject_arbiter_if.sv
// Requester/router handshake bundle for the inject arbiter.
// Master drives flits and credit returns; slave is the arbiter.
interface inject_arbiter_if;
    logic [19:0] req_flit0;
    logic [19:0] req_flit1;
    logic [19:0] req_flit2;
    logic [19:0] req_flit3;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [19:0] dataout;
    logic        out_valid;
    logic        ci;

    modport master (
        output req_flit0, req_flit1, req_flit2, req_flit3, req_valid, ci,
        input  req_ready, dataout, out_valid
    );

    modport slave (
        input  req_flit0, req_flit1, req_flit2, req_flit3, req_valid, ci,
        output req_ready, dataout, out_valid
    );
endinterface

// File: rtl/inject_arbiter.sv
// Four-requester, packet-locking round-robin arbiter feeding a router inject
// port under credit-based flow control, with a sticky protocol error flag.
module inject_arbiter #(
    parameter int unsigned CREDIT_MAX = 4
) (
    input  logic                   clk,
    input  logic                   RST,
    inject_arbiter_if.slave        bus,
    output logic [2:0]             credit_cnt,
    output logic [1:0]             grant_id,
    output logic                   err
);

    typedef enum logic {IDLE, LOCKED} state_t;
    typedef enum logic [1:0] {BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, SINGLE = 2'b11} flit_t;

    localparam logic [2:0] CMAX = 3'(CREDIT_MAX);

    state_t      state_q, state_d;
    logic [2:0]  credit_q, credit_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic        err_q, err_d;
    logic        out_valid_q, out_valid_d;
    logic [19:0] dataout_q, dataout_d;

    logic [19:0] flit [4];
    logic        gnt;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand;
    logic [19:0] gnt_flit;
    flit_t       ftype;
    logic        drop;
    logic        fwd;

    assign flit[0] = bus.req_flit0;
    assign flit[1] = bus.req_flit1;
    assign flit[2] = bus.req_flit2;
    assign flit[3] = bus.req_flit3;

    // grant_id_q doubles as round-robin pointer in IDLE and packet owner in LOCKED
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = grant_id_q;
        cand    = '0;
        if (!RST && credit_q != '0) begin
            if (state_q == LOCKED) begin
                gnt = bus.req_valid[grant_id_q];
            end else begin
                for (int unsigned k = 1; k <= 4; k++) begin
                    cand = grant_id_q + 2'(k);
                    if (!gnt && bus.req_valid[cand]) begin
                        gnt     = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
    end

    assign gnt_flit      = flit[gnt_idx];
    assign ftype         = flit_t'(gnt_flit[19:18]);
    assign drop          = gnt && state_q == IDLE && (ftype == BODY || ftype == TAIL);
    assign fwd           = gnt && !drop;
    assign bus.req_ready = gnt ? (4'b0001 << gnt_idx) : '0;

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        grant_id_d  = grant_id_q;
        err_d       = err_q;
        out_valid_d = fwd;
        dataout_d   = fwd ? gnt_flit : dataout_q;

        if (gnt) grant_id_d = gnt_idx;

        if (state_q == IDLE && fwd && ftype == HEAD) state_d = LOCKED;
        if (state_q == LOCKED && gnt && ftype == TAIL) state_d = IDLE;

        if (drop) err_d = 1'b1;
        if (state_q == LOCKED && gnt && (ftype == HEAD || ftype == SINGLE)) err_d = 1'b1;
        if (bus.ci && !fwd && credit_q == CMAX) err_d = 1'b1;

        // A forward and a credit return in the same cycle cancel out
        case ({fwd, bus.ci})
            2'b10:   credit_d = credit_q - 3'd1;
            2'b01:   if (credit_q != CMAX) credit_d = credit_q + 3'd1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            credit_q    <= CMAX;
            grant_id_q  <= 2'd3;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dataout_q   <= '0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            grant_id_q  <= grant_id_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            dataout_q   <= dataout_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dataout   = dataout_q;
    assign credit_cnt    = credit_q;
    assign grant_id      = grant_id_q;
    assign err           = err_q;

endmodule

// File: tb/tb_inject_arbiter.sv
// Directed-vector bench for inject_arbiter with hand-computed expectations.
module tb_inject_arbiter;

    logic       clk;
    logic       RST;
    logic [2:0] credit_cnt;
    logic [1:0] grant_id;
    logic       err;

    int unsigned n_tests;
    int unsigned n_fail;

    inject_arbiter_if bus ();

    inject_arbiter #(.CREDIT_MAX(4)) dut (
        .clk        (clk),
        .RST        (RST),
        .bus        (bus),
        .credit_cnt (credit_cnt),
        .grant_id   (grant_id),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; registered outputs settle 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] mk(input logic [1:0] t, input logic [17:0] d);
        return {t, d};
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        bus.req_valid = 4'b0000;
        bus.ci = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    logic [19:0] exp_flit [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST = 1'b1;
        bus.ci = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_flit0 = '0;
        bus.req_flit1 = '0;
        bus.req_flit2 = '0;
        bus.req_flit3 = '0;
        tick();
        tick();
        // Reset state, req_ready gated while RST is high
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_credit", 32'(credit_cnt), 32'd4);
        check("rst_gid", 32'(grant_id), 32'd3);
        check("rst_ov", 32'(bus.out_valid), 32'd0);
        check("rst_dout", 32'(bus.dataout), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Round robin over four singles with ci tied high
        RST = 1'b0;
        bus.ci = 1'b1;
        for (int i = 0; i < 4; i++) exp_flit[i] = mk(2'b11, 18'(32'h100 + i));
        bus.req_flit0 = exp_flit[0];
        bus.req_flit1 = exp_flit[1];
        bus.req_flit2 = exp_flit[2];
        bus.req_flit3 = exp_flit[3];
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            check("rr_ov", 32'(bus.out_valid), 32'd1);
            check("rr_dout", 32'(bus.dataout), 32'(exp_flit[k % 4]));
            check("rr_gid", 32'(grant_id), 32'(k % 4));
            check("rr_credit", 32'(credit_cnt), 32'd4);
        end
        check("rr_err", 32'(err), 32'd0);

        // Packet lock on requester 2 while requester 1 competes
        bus.req_valid = 4'b0100;
        bus.req_flit2 = mk(2'b01, 18'h2A0);
        #1;
        check("lk_head_ready", 32'(bus.req_ready), 32'h4);
        tick();
        check("lk_head_dout", 32'(bus.dataout), 32'(mk(2'b01, 18'h2A0)));
        check("lk_head_gid", 32'(grant_id), 32'd2);
        bus.req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            bus.req_flit2 = (k == 2) ? mk(2'b10, 18'(32'h2A1 + k)) : mk(2'b00, 18'(32'h2A1 + k));
            #1;
            check("lk_ready", 32'(bus.req_ready), 32'h4);
            tick();
            check("lk_ov", 32'(bus.out_valid), 32'd1);
            check("lk_dout", 32'(bus.dataout), 32'(bus.req_flit2));
        end
        bus.req_valid = 4'b1010;
        #1;
        check("lk_next_ready", 32'(bus.req_ready), 32'h8);
        tick();
        check("lk_next_gid", 32'(grant_id), 32'd3);
        check("lk_next_dout", 32'(bus.dataout), 32'(exp_flit[3]));
        check("lk_err", 32'(err), 32'd0);
        bus.req_valid = 4'b0000;
        bus.ci = 1'b0;
        tick();
        check("idle_ov", 32'(bus.out_valid), 32'd0);
        check("idle_dout_hold", 32'(bus.dataout), 32'(exp_flit[3]));

        // Credit exhaustion and single-credit refill
        do_reset();
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cr_ready", 32'(bus.req_ready), 32'h1);
            tick();
            check("cr_credit", 32'(credit_cnt), 32'(3 - k));
        end
        #1;
        check("cr_zero_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check("cr_zero_ov", 32'(bus.out_valid), 32'd0);
        check("cr_zero_credit", 32'(credit_cnt), 32'd0);
        bus.ci = 1'b1;
        #1;
        check("cr_ci_nogrant", 32'(bus.req_ready), 32'h0);
        tick();
        check("cr_ci_credit", 32'(credit_cnt), 32'd1);
        bus.ci = 1'b0;
        #1;
        check("cr_one_ready", 32'(bus.req_ready), 32'h1);
        tick();
        check("cr_one_ov", 32'(bus.out_valid), 32'd1);
        check("cr_one_credit", 32'(credit_cnt), 32'd0);
        #1;
        check("cr_again_ready", 32'(bus.req_ready), 32'h0);

        // Simultaneous forward + ci at 2, then overflow ci at max
        bus.req_valid = 4'b0000;
        bus.ci = 1'b1;
        tick();
        tick();
        check("ci_two", 32'(credit_cnt), 32'd2);
        bus.req_valid = 4'b0001;
        tick();
        check("ci_fwd_same", 32'(credit_cnt), 32'd2);
        check("ci_fwd_ov", 32'(bus.out_valid), 32'd1);
        bus.req_valid = 4'b0000;
        tick();
        tick();
        check("ci_full", 32'(credit_cnt), 32'd4);
        check("ci_full_err", 32'(err), 32'd0);
        tick();
        check("ci_over_credit", 32'(credit_cnt), 32'd4);
        check("ci_over_err", 32'(err), 32'd1);
        bus.ci = 1'b0;

        // Stray body flit in IDLE is consumed and dropped
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_flit1 = mk(2'b00, 18'h155);
        #1;
        check("drop_ready", 32'(bus.req_ready), 32'h2);
        tick();
        check("drop_ov", 32'(bus.out_valid), 32'd0);
        check("drop_credit", 32'(credit_cnt), 32'd4);
        check("drop_err", 32'(err), 32'd1);
        check("drop_gid", 32'(grant_id), 32'd1);

        // Reset mid-packet abandons the lock held by requester 3
        do_reset();
        check("mid_err_clr", 32'(err), 32'd0);
        bus.req_valid = 4'b1000;
        bus.req_flit3 = mk(2'b01, 18'h333);
        #1;
        check("mid_head_ready", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_flit3 = mk(2'b00, 18'h334);
        bus.req_valid = 4'b1001;
        bus.req_flit0 = mk(2'b11, 18'h001);
        #1;
        check("mid_body_ready", 32'(bus.req_ready), 32'h8);
        tick();
        check("mid_credit", 32'(credit_cnt), 32'd2);
        RST = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        RST = 1'b0;
        check("mid_rst_credit", 32'(credit_cnt), 32'd4);
        check("mid_rst_ov", 32'(bus.out_valid), 32'd0);
        check("mid_rst_gid", 32'(grant_id), 32'd3);
        #1;
        check("mid_next_ready", 32'(bus.req_ready), 32'h1);
        tick();
        check("mid_next_dout", 32'(bus.dataout), 32'(mk(2'b11, 18'h001)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
